memory_arbiter: RTL

Arbitrates the processor's instruction-fetch and data-access requests onto a single-ported RAM. Sits directly downstream of the request unit and instruction fetch: it consumes iREN/dREN/dWEN plus addresses and store data, serialises them to the RAM, and returns per-port hit strobes and load data. Data accesses take priority over instruction fetches. A per-transaction watchdog aborts RAM accesses that never complete.

---
 rtl/memory_arbiter_if.sv | 35 +++
 rtl/memory_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/memory_arbiter_if.sv
// Bundles the instruction/data request ports and the single-ported RAM bus.
// The arbiter takes the slave view; the environment drives through the master view.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic [31:0] iload;
  logic        dhit;
  logic [31:0] dload;
  logic        iwait;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, iwait, dwait,
           ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, iwait, dwait,
           ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/memory_arbiter.sv
// Serialises instruction fetches and data accesses onto one RAM port, data first,
// with a per-transaction watchdog that aborts accesses the RAM never completes.
module memory_arbiter #(
  parameter int WAIT_MAX = 15
) (
  input  logic            CLK,
  input  logic            RST,
  memory_arbiter_if.slave bus
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } state_t;

  state_t        state;
  state_t        nextState;
  logic [31:0]   addrReg;
  logic [31:0]   storeReg;
  logic          opWrite;
  logic [CW-1:0] waitCnt;
  logic          errReg;

  logic timeout;
  logic granted;
  logic aborted;
  logic iHit;
  logic dHit;
  logic dataWrite;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  // The watchdog is checked before ACCESS so a timed-out transaction never hits.
  always_comb begin
    nextState = state;
    granted   = 1'b0;
    aborted   = 1'b0;
    timeout   = (waitCnt == CNT_MAX);
    case (state)
      IDLE: begin
        if (bus.dWEN || bus.dREN) nextState = DACC;
        else if (bus.iREN)        nextState = IACC;
      end
      DACC, IACC: begin
        if (timeout || bus.ramstate == RAM_ERROR) begin
          aborted   = 1'b1;
          nextState = IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          granted   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase

    iHit      = granted && (state == IACC);
    dHit      = granted && (state == DACC);
    dataWrite = (state == DACC) && opWrite;

    bus.ihit     = iHit;
    bus.dhit     = dHit;
    bus.iload    = iHit ? bus.ramload : 32'd0;
    bus.dload    = (dHit && !opWrite) ? bus.ramload : 32'd0;
    bus.iwait    = bus.iREN && !iHit;
    bus.dwait    = (bus.dREN || bus.dWEN) && !dHit;
    bus.ramREN   = (state == IACC) || ((state == DACC) && !opWrite);
    bus.ramWEN   = dataWrite;
    bus.ramaddr  = (state != IDLE) ? addrReg : 32'd0;
    bus.ramstore = dataWrite ? storeReg : 32'd0;
    bus.err      = errReg;
  end

  // Request capture happens only in IDLE, so a withdrawn request cannot disturb
  // the transaction already on the RAM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addrReg  <= 32'd0;
      storeReg <= 32'd0;
      opWrite  <= 1'b0;
      waitCnt  <= '0;
      errReg   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        waitCnt <= '0;
        if (bus.dWEN || bus.dREN) begin
          addrReg  <= bus.daddr;
          storeReg <= bus.dstore;
          opWrite  <= bus.dWEN;
        end else if (bus.iREN) begin
          addrReg <= bus.iaddr;
          opWrite <= 1'b0;
        end
      end else if (bus.ramstate != RAM_ACCESS && !timeout) begin
        waitCnt <= waitCnt + CW'(1);
      end
      if (aborted) errReg <= 1'b1;
    end
  end

endmodule
